seq_barrel_shifter: RTL and testbench

//  Parametrised multi-cycle ARM shifter operand unit for the execute stage. Accepts one shift

---
 rtl/seq_barrel_shifter.sv | 132 +++++++++++++
 tb/tb_seq_barrel_shifter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_barrel_shifter.sv
// seq_barrel_shifter: multi-cycle ARM shifter operand unit, STEP bits per cycle, valid/ready on both sides
module seq_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       op_type,
    input  logic             imm_mode,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out
);
    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] N_C    = CW'(WIDTH);
    localparam logic [CW-1:0] STEP_C = CW'(STEP);
    localparam logic [1:0] LSL = 2'd0;
    localparam logic [1:0] LSR = 2'd1;
    localparam logic [1:0] ASR = 2'd2;
    localparam logic [1:0] ROR = 2'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic             kill_q, kill_d;
    logic             rrx_q, rrx_d;

    logic [AMT_W-1:0] a;
    logic [CW-1:0]    a_clip, rot, dec_k, s;
    logic             a_over, dec_c, dec_kill, dec_rrx;
    logic [LW-1:0]    lo_idx, hi_idx;
    logic [WIDTH-1:0] shift_v;
    logic             shift_c;

    assign a       = imm_mode ? AMT_W'(amount[LW-1:0]) : amount;
    assign a_over  = 32'(a) > 32'(WIDTH);
    assign a_clip  = 32'(a) >= 32'(WIDTH) ? N_C : CW'(a);
    assign rot     = CW'(a[LW-1:0]);
    assign dec_rrx = imm_mode && op_type == ROR && a == '0;

    // Amounts past N are clipped to N cycles; kill forces the ARM-mandated zero carry for LSL/LSR
    always_comb begin
        dec_k    = '0;
        dec_c    = c_in;
        dec_kill = 1'b0;
        if (a == '0) begin
            if (imm_mode && (op_type == LSR || op_type == ASR))
                dec_k = N_C;
            else if (dec_rrx)
                dec_k = CW'(1);
        end else if (op_type == ROR) begin
            dec_k = rot;
            dec_c = rot == '0 ? operand[WIDTH-1] : c_in;
        end else begin
            dec_k    = a_clip;
            dec_kill = a_over && op_type != ASR;
        end
    end

    assign s       = rem_q > STEP_C ? STEP_C : rem_q;
    assign lo_idx  = LW'(s - 1'b1);
    assign hi_idx  = LW'(N_C - s);
    assign shift_v = op_q == LSL ? val_q << s :
                     op_q == LSR ? val_q >> s :
                     op_q == ASR ? $unsigned($signed(val_q) >>> s) :
                     rrx_q       ? {carry_q, val_q[WIDTH-1:1]} :
                                   (val_q >> s) | (val_q << (N_C - s));
    assign shift_c = op_q == LSL ? val_q[hi_idx] : val_q[lo_idx];

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        op_d    = op_q;
        kill_d  = kill_q;
        rrx_d   = rrx_q;
        if (state_q == IDLE && in_valid) begin
            state_d = dec_k == '0 ? DONE : SHIFT;
            val_d   = operand;
            carry_d = dec_c;
            rem_d   = dec_k;
            op_d    = op_type;
            kill_d  = dec_kill;
            rrx_d   = dec_rrx;
        end else if (state_q == SHIFT) begin
            state_d = rem_q == s ? DONE : SHIFT;
            val_d   = shift_v;
            carry_d = shift_c && !kill_q;
            rem_d   = rem_q - s;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
            op_q    <= LSL;
            kill_q  <= 1'b0;
            rrx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            kill_q  <= kill_d;
            rrx_q   <= rrx_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = val_q;
    assign c_out     = carry_q;
endmodule

// File: tb/tb_seq_barrel_shifter.sv
// tb_seq_barrel_shifter: table vectors, directed handshake/reset sequences and random checks against an ARM shift model
module tb_seq_barrel_shifter;
    logic        clk = 0, reset = 1, in_valid = 0, imm_mode = 0, c_in = 0, out_ready = 0;
    logic        in_ready, out_valid, c_out;
    logic [31:0] operand = 0, result;
    logic [7:0]  amount = 0;
    logic [1:0]  op_type = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_barrel_shifter #(.WIDTH(32), .STEP(8), .AMT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .operand(operand), .amount(amount), .op_type(op_type), .imm_mode(imm_mode),
        .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready), .result(result), .c_out(c_out)
    );

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  amt;
        logic        imm;
        logic [31:0] x;
        logic        ci;
        logic [31:0] r;
        logic        c;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [7:0] amt, input logic imm,
                                  input logic [31:0] x, input logic ci,
                                  output logic [31:0] r, output logic c, output int lat);
        int a, k;
        logic [31:0] t;
        logic signed [31:0] sx;
        sx = x;
        a = imm ? int'(amt) % 32 : int'(amt);
        k = 0;
        r = x;
        c = ci;
        if (a == 0) begin
            if (imm && op == 2'd1) begin r = 0; c = x[31]; k = 32; end
            else if (imm && op == 2'd2) begin r = {32{x[31]}}; c = x[31]; k = 32; end
            else if (imm && op == 2'd3) begin r = {ci, x[31:1]}; c = x[0]; k = 1; end
        end else if (op == 2'd3) begin
            k = a % 32;
            r = (x >> k) | (x << (32 - k));
            c = r[31];
        end else begin
            k = a > 32 ? 32 : a;
            if (op == 2'd2 && a >= 32) begin r = {32{x[31]}}; c = x[31]; end
            else if (a > 32) begin r = 0; c = 0; end
            else if (a == 32) begin r = 0; c = op == 2'd0 ? x[0] : x[31]; end
            else if (op == 2'd0) begin r = x << a; t = x >> (32 - a); c = t[0]; end
            else begin
                if (op == 2'd1) r = x >> a;
                else r = sx >>> a;
                t = x >> (a - 1);
                c = t[0];
            end
        end
        lat = k == 0 ? 1 : 1 + (k + 7) / 8;
    endfunction

    task automatic run(input logic [1:0] op, input logic [7:0] amt, input logic imm,
                       input logic [31:0] x, input logic ci, input logic [31:0] er,
                       input logic ec, input int el, input int hold, input string nm);
        int lat;
        @(negedge clk);
        chk({nm, " in_ready"}, 32'(in_ready), 1);
        op_type = op; amount = amt; imm_mode = imm; operand = x; c_in = ci; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 64);
        chk({nm, " latency"}, lat, el);
        chk({nm, " result"}, result, er);
        chk({nm, " c_out"}, 32'(c_out), 32'(ec));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " held"}, {c_out, out_valid, result[29:0]}, {ec, 1'b1, er[29:0]});
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er;
        logic        ec;
        int          el, lat;
        logic [1:0]  op;
        logic [7:0]  amt;
        logic        imm, ci;
        logic [31:0] x;

        vecs[0]  = '{2'd0, 8'd4,   1'b0, 32'h8000_000F, 1'b0, 32'h0000_00F0, 1'b0, 2};
        vecs[1]  = '{2'd1, 8'd0,   1'b1, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 5};
        vecs[2]  = '{2'd3, 8'd0,   1'b1, 32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 2};
        vecs[3]  = '{2'd2, 8'd200, 1'b0, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 5};
        vecs[4]  = '{2'd3, 8'd64,  1'b0, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1};
        vecs[5]  = '{2'd0, 8'd32,  1'b0, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 5};
        vecs[6]  = '{2'd0, 8'd33,  1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 5};
        vecs[7]  = '{2'd1, 8'd32,  1'b0, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 5};
        vecs[8]  = '{2'd1, 8'd8,   1'b1, 32'h0000_0180, 1'b0, 32'h0000_0001, 1'b1, 2};
        vecs[9]  = '{2'd3, 8'd4,   1'b1, 32'h0000_001F, 1'b0, 32'hF000_0001, 1'b1, 2};
        vecs[10] = '{2'd2, 8'd0,   1'b1, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 5};
        vecs[11] = '{2'd0, 8'd0,   1'b0, 32'h0000_1234, 1'b1, 32'h0000_1234, 1'b1, 1};
        vecs[12] = '{2'd3, 8'd36,  1'b0, 32'h0000_0010, 1'b1, 32'h0000_0001, 1'b0, 2};
        vecs[13] = '{2'd0, 8'd9,   1'b1, 32'h0080_0001, 1'b0, 32'h0000_0200, 1'b1, 3};
        vecs[14] = '{2'd1, 8'h21,  1'b1, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 2};

        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset result", result, 0);
        chk("reset c_out", 32'(c_out), 0);

        foreach (vecs[i])
            run(vecs[i].op, vecs[i].amt, vecs[i].imm, vecs[i].x, vecs[i].ci,
                vecs[i].r, vecs[i].c, vecs[i].lat, i % 3, $sformatf("vec%0d", i));

        // backpressure: second request held on in_valid while the first result waits
        @(negedge clk);
        op_type = 2'd0; amount = 8'd4; imm_mode = 0; operand = 32'h8000_000F; c_in = 0; in_valid = 1;
        @(posedge clk);
        #1 op_type = 2'd1; amount = 8'd4; operand = 32'h0000_00F0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 64);
        chk("bp first latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp held result", result, 32'h0000_00F0);
            chk("bp in_ready low", 32'(in_ready), 0);
            chk("bp out_valid", 32'(out_valid), 1);
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("bp idle out_valid", 32'(out_valid), 0);
        chk("bp idle in_ready", 32'(in_ready), 1);
        chk("bp idle result", result, 32'h0000_00F0);
        @(posedge clk);
        #1 in_valid = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 64);
        chk("bp second latency", lat, 2);
        chk("bp second result", result, 32'h0000_000F);
        chk("bp second c_out", 32'(c_out), 0);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;

        // reset in the middle of a multi-cycle shift
        @(negedge clk);
        op_type = 2'd0; amount = 8'd24; imm_mode = 0; operand = 32'hFFFF_FFFF; c_in = 1; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("mid busy in_ready", 32'(in_ready), 0);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("mid reset out_valid", 32'(out_valid), 0);
        chk("mid reset result", result, 0);
        chk("mid reset c_out", 32'(c_out), 0);
        chk("mid reset in_ready", 32'(in_ready), 1);
        repeat (4) begin
            @(negedge clk);
            chk("mid reset no stale out", 32'(out_valid), 0);
        end
        run(2'd0, 8'd0, 1'b0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 1, 0, "post reset");

        for (int n = 0; n < 150; n++) begin
            op  = 2'($urandom_range(0, 3));
            imm = 1'($urandom_range(0, 1));
            ci  = 1'($urandom_range(0, 1));
            x   = $urandom;
            case ($urandom_range(0, 3))
                0: amt = 8'd0;
                1: amt = 8'($urandom_range(0, 7) * 32);
                2: amt = 8'($urandom_range(1, 40));
                default: amt = 8'($urandom_range(0, 255));
            endcase
            model(op, amt, imm, x, ci, er, ec, el);
            run(op, amt, imm, x, ci, er, ec, el, $urandom_range(0, 2),
                $sformatf("rand%0d op%0d amt%0d imm%0d", n, op, amt, imm));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
